// File: rtl/multicycle_cpu.sv
// multicycle_cpu: RV32I/RV64I OP and OP-IMM subset, FETCH/DECODE/EXEC/WB.
// Ports: clk_i, rst_i (async, active-low), start_i, imem_*, retire_o, halted_o, dbg_*.
module multicycle_cpu #(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic            retire_o,
    output logic            halted_o,
    input  logic [4:0]      dbg_raddr_i,
    output logic [XLEN-1:0] dbg_rdata_o
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WB, HALT
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] result;
    logic [31:0]     ir;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [XLEN-1:0] regs [NUM_REGS];

    logic            is_op;
    logic            is_imm;
    logic            shift_ok;
    logic            idx_ok;
    logic            legal;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu;

    assign is_op  = ir[6:0] == 7'b0110011;
    assign is_imm = ir[6:0] == 7'b0010011;

    // Immediate shifts: IR[30] selects SRAI, IR[25] is a shamt bit only on RV64.
    assign shift_ok = !ir[31] && ir[29:26] == 4'b0
                      && (XLEN == 64 || !ir[25]);

    // rs2 is only a register index for OP; in OP-IMM it is immediate bits.
    assign idx_ok = int'(ir[11:7]) < NUM_REGS
                    && int'(ir[19:15]) < NUM_REGS
                    && (!is_op || int'(ir[24:20]) < NUM_REGS);

    always_comb begin
        legal = 1'b0;
        if (is_op) begin
            legal = ir[31:25] == 7'b0000000
                    || (ir[31:25] == 7'b0100000
                        && (ir[14:12] == 3'b000 || ir[14:12] == 3'b101));
        end else if (is_imm) begin
            unique case (ir[14:12])
                3'b001:  legal = shift_ok && !ir[30];
                3'b101:  legal = shift_ok;
                default: legal = 1'b1;
            endcase
        end
        legal = legal && idx_ok;
    end

    assign op_a  = regs[rs1];
    assign op_b  = is_op ? regs[rs2] : imm;
    assign shamt = op_b[SW-1:0];

    always_comb begin
        alu = '0;
        unique case (ir[14:12])
            3'b000: alu = (is_op && ir[30]) ? op_a - op_b : op_a + op_b;
            3'b001: alu = op_a << shamt;
            3'b010: alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b011: alu = {{(XLEN-1){1'b0}}, op_a < op_b};
            3'b100: alu = op_a ^ op_b;
            3'b101: alu = ir[30] ? $unsigned($signed(op_a) >>> shamt)
                                 : op_a >> shamt;
            3'b110: alu = op_a | op_b;
            3'b111: alu = op_a & op_b;
            default: alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_i) state_nxt = FETCH;
            FETCH:   if (imem_ack_i) state_nxt = DECODE;
            DECODE:  state_nxt = legal ? EXEC : HALT;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them at once.
    always_comb begin
        imem_req_o = state == FETCH;
        retire_o   = state == WB;
        halted_o   = state == HALT;
    end

    assign imem_addr_o = pc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc     <= RESET_PC;
            ir     <= '0;
            rs1    <= '0;
            rs2    <= '0;
            imm    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                FETCH: if (imem_ack_i) ir <= imem_data_i;
                DECODE: begin
                    rs1 <= ir[15 +: RW];
                    rs2 <= ir[20 +: RW];
                    imm <= {{(XLEN-12){ir[31]}}, ir[31:20]};
                end
                EXEC:    result <= alu;
                WB:      pc <= pc + XLEN'(4);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (state == WB && ir[11:7] != 5'd0) begin
            regs[ir[7 +: RW]] <= result;
        end
    end

    assign dbg_rdata_o = (dbg_raddr_i != 5'd0 && int'(dbg_raddr_i) < NUM_REGS)
                         ? regs[dbg_raddr_i[RW-1:0]] : '0;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: scoreboard bench for multicycle_cpu.
// Ports: none; drives a default core and a NUM_REGS=16 core.
module tb_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        ack = 1'b0;
    logic [31:0] data = '0;
    logic        retire;
    logic        halted;
    logic [4:0]  dbg = '0;
    logic [31:0] dbg_rdata;

    logic        start_b = 1'b0;
    logic        req_b;
    logic [31:0] addr_b;
    logic        ack_b = 1'b0;
    logic [31:0] data_b = '0;
    logic        retire_b;
    logic        halted_b;
    logic [4:0]  dbg_b = '0;
    logic [31:0] dbg_rdata_b;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc = '0;

    always #5 clk = ~clk;

    multicycle_cpu dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_data_i(data),
        .retire_o(retire), .halted_o(halted),
        .dbg_raddr_i(dbg), .dbg_rdata_o(dbg_rdata)
    );

    multicycle_cpu #(
        .XLEN(32), .NUM_REGS(16), .RESET_PC(32'h100)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .imem_req_o(req_b), .imem_addr_o(addr_b),
        .imem_ack_i(ack_b), .imem_data_i(data_b),
        .retire_o(retire_b), .halted_o(halted_b),
        .dbg_raddr_i(dbg_b), .dbg_rdata_o(dbg_rdata_b)
    );

    function automatic logic [31:0] op_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] op_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic run_instr(input logic [31:0] word, input int dly,
        input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        int   c;
        int   n;
        bit   seen;
        sb.push_back('{rd, val});
        n = 0;
        while (req !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req !== 1'b1) begin
            bad++;
            $display("FAIL req_wait: req=%b want 1", req);
            e = sb.pop_front();
            return;
        end
        total++;
        if (addr !== exp_pc) begin
            bad++;
            $display("FAIL fetch_addr: got %h want %h", addr, exp_pc);
        end
        c = 1;
        for (int i = 0; i < dly; i++) begin
            ack = 1'b0;
            @(negedge clk);
            c++;
            total++;
            if (req !== 1'b1 || addr !== exp_pc) begin
                bad++;
                $display("FAIL fetch_hold: req=%b addr=%h want 1 %h",
                         req, addr, exp_pc);
            end
        end
        ack  = 1'b1;
        data = word;
        @(negedge clk);
        ack  = 1'b0;
        data = '0;
        c++;
        seen = 1'b0;
        while (!seen && c < dly + 10) begin
            if (retire === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                c++;
            end
        end
        e = sb.pop_front();
        total++;
        if (!seen || c != dly + 4) begin
            bad++;
            $display("FAIL retire_cycle: seen=%b cycle=%0d want %0d",
                     seen, c, dly + 4);
        end
        if (!seen) return;
        @(negedge clk);
        total++;
        if (retire !== 1'b0) begin
            bad++;
            $display("FAIL retire_width: retire=%b want 0", retire);
        end
        exp_pc = exp_pc + 32'd4;
        dbg = e.rd;
        #1;
        total++;
        if (dbg_rdata !== e.val) begin
            bad++;
            $display("FAIL reg_x%0d: got %h want %h", e.rd, dbg_rdata, e.val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (req !== 1'b0 || retire !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: req=%b ret=%b hlt=%b want 000",
                     req, retire, halted);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        dbg = 5'd1;
        #1;
        total++;
        if (req !== 1'b0 || addr !== 32'h0 || dbg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle: req=%b addr=%h x1=%h want 0 0 0",
                     req, addr, dbg_rdata);
        end
    endtask

    task automatic test_addi();
        start = 1'b1;
        run_instr(op_i(12'd5, 5'd0, 3'b000, 5'd1), 0, 5'd1, 32'd5);
        start = 1'b0;
        total++;
        if (addr !== 32'd4) begin
            bad++;
            $display("FAIL next_pc: got %h want 4", addr);
        end
    endtask

    task automatic test_alu();
        run_instr(op_i(12'hFFF, 5'd0, 3'b000, 5'd1), 0, 5'd1, 32'hFFFFFFFF);
        run_instr(op_i(12'h004, 5'd1, 3'b101, 5'd2), 0, 5'd2, 32'h0FFFFFFF);
        run_instr(op_i(12'h404, 5'd1, 3'b101, 5'd3), 0, 5'd3, 32'hFFFFFFFF);
        run_instr(op_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), 0, 5'd4, 32'h0FFFFFFE);
        run_instr(op_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd5), 0, 5'd5, 32'h1);
        run_instr(op_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd6), 0, 5'd6, 32'h1);
        run_instr(op_r(7'h00, 5'd0, 5'd1, 3'b011, 5'd7), 0, 5'd7, 32'h0);
        run_instr(op_i(12'hFFF, 5'd2, 3'b100, 5'd8), 0, 5'd8, 32'hF0000000);
        run_instr(op_i(12'h01F, 5'd1, 3'b001, 5'd9), 0, 5'd9, 32'h80000000);
    endtask

    task automatic test_wait();
        run_instr(op_i(12'h7FF, 5'd0, 3'b000, 5'd10), 3, 5'd10, 32'h7FF);
    endtask

    task automatic test_x0();
        run_instr(op_i(12'd7, 5'd0, 3'b000, 5'd0), 0, 5'd0, 32'h0);
    endtask

    task automatic test_back_to_back();
        run_instr(op_i(12'h0F0, 5'd1, 3'b111, 5'd11),
                  int'($urandom_range(0, 2)), 5'd11, 32'hF0);
        run_instr(op_i(12'h00F, 5'd11, 3'b110, 5'd12),
                  int'($urandom_range(0, 2)), 5'd12, 32'hFF);
        run_instr(op_i(12'h001, 5'd0, 3'b011, 5'd13),
                  int'($urandom_range(0, 2)), 5'd13, 32'h1);
        run_instr(op_i(12'h000, 5'd1, 3'b010, 5'd14),
                  int'($urandom_range(0, 2)), 5'd14, 32'h1);
        run_instr(op_r(7'h00, 5'd13, 5'd13, 3'b001, 5'd15),
                  int'($urandom_range(0, 2)), 5'd15, 32'h2);
        run_instr(op_r(7'h00, 5'd13, 5'd9, 3'b101, 5'd16),
                  int'($urandom_range(0, 2)), 5'd16, 32'h40000000);
        run_instr(op_r(7'h00, 5'd12, 5'd11, 3'b100, 5'd17),
                  int'($urandom_range(0, 2)), 5'd17, 32'h0F);
        run_instr(op_r(7'h00, 5'd11, 5'd12, 3'b111, 5'd18),
                  int'($urandom_range(0, 2)), 5'd18, 32'hF0);
        run_instr(op_r(7'h20, 5'd13, 5'd1, 3'b101, 5'd19),
                  int'($urandom_range(0, 2)), 5'd19, 32'hFFFFFFFF);
    endtask

    task automatic test_reset_midfetch();
        bit stray;
        total++;
        if (req !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_req: req=%b want 1", req);
        end
        #2;
        rst  = 1'b0;
        ack  = 1'b1;
        data = op_i(12'd3, 5'd0, 3'b000, 5'd1);
        #1;
        total++;
        if (req !== 1'b0 || addr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: req=%b addr=%h want 0 0", req, addr);
        end
        @(negedge clk);
        rst = 1'b1;
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (req !== 1'b0 || retire !== 1'b0) stray = 1'b1;
        end
        ack  = 1'b0;
        data = '0;
        dbg  = 5'd1;
        #1;
        total++;
        if (stray || dbg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL post_reset_idle: stray=%b x1=%h want 0 0",
                     stray, dbg_rdata);
        end
        exp_pc = '0;
        start  = 1'b1;
        run_instr(op_i(12'd9, 5'd0, 3'b000, 5'd2), 1, 5'd2, 32'd9);
        start = 1'b0;
    endtask

    task automatic test_halt_zero();
        bit stray;
        int n;
        n = 0;
        while (req !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        ack  = 1'b1;
        data = 32'h0;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_entry: halted=%b want 1", halted);
        end
        stray = 1'b0;
        start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1)
                stray = 1'b1;
        end
        start = 1'b0;
        total++;
        if (stray || addr !== exp_pc) begin
            bad++;
            $display("FAIL halt_hold: stray=%b addr=%h want 0 %h",
                     stray, addr, exp_pc);
        end
    endtask

    task automatic test_narrow_regs();
        int n;
        bit stray;
        start_b = 1'b1;
        n = 0;
        while (req_b !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_b !== 1'b1 || addr_b !== 32'h100) begin
            bad++;
            $display("FAIL narrow_fetch: req=%b addr=%h want 1 100",
                     req_b, addr_b);
        end
        ack_b  = 1'b1;
        data_b = op_i(12'd1, 5'd0, 3'b000, 5'd20);
        @(negedge clk);
        ack_b   = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        total++;
        if (halted_b !== 1'b1) begin
            bad++;
            $display("FAIL narrow_halt: halted=%b want 1", halted_b);
        end
        stray = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (retire_b !== 1'b0 || req_b !== 1'b0) stray = 1'b1;
        end
        dbg_b = 5'd20;
        #1;
        total++;
        if (stray || dbg_rdata_b !== 32'h0) begin
            bad++;
            $display("FAIL narrow_hold: stray=%b x20=%h want 0 0",
                     stray, dbg_rdata_b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi();
        test_alu();
        test_wait();
        test_x0();
        test_back_to_back();
        test_reset_midfetch();
        test_halt_zero();
        test_narrow_regs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
